// File: rtl/lcd_cmd_sequencer_if.sv
// Command/handshake bundle between the host-side sequencer and the LCD controller.
// The sequencer drives cmd/cmd_valid; the controller answers with busy/done and its
// IRAM pixel write burst, which terminates in the sequencer's frame buffer.
interface lcd_cmd_sequencer_if;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic       busy;
    logic       done;
    logic       IRAM_valid;
    logic [5:0] IRAM_A;
    logic [7:0] IRAM_D;

    modport master (
        output cmd,
        output cmd_valid,
        input  busy,
        input  done,
        input  IRAM_valid,
        input  IRAM_A,
        input  IRAM_D
    );

    modport slave (
        input  cmd,
        input  cmd_valid,
        output busy,
        output done,
        output IRAM_valid,
        output IRAM_A,
        output IRAM_D
    );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// Host-side initiator for the LCD controller command port. Plays a loadable script of
// 4-bit commands one at a time, paced on the controller's busy flag, captures each
// pixel write burst into a local 64-entry frame buffer and raises a sticky error flag
// on any protocol violation (stray pixels/done, short or long bursts, repeated addresses).
module lcd_cmd_sequencer #(
    parameter int  DEPTH = 64,
    parameter int  NPIX  = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_we,
    input  logic [AW-1:0]              cfg_addr,
    input  logic [3:0]                 cfg_cmd,
    input  logic [AW:0]                cfg_len,
    input  logic                       start,
    lcd_cmd_sequencer_if.master        lcd,
    input  logic [5:0]                 fb_addr,
    output logic [7:0]                 fb_data,
    output logic [6:0]                 cap_cnt,
    output logic                       seq_busy,
    output logic                       seq_done,
    output logic                       err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_RDY = 3'd1;
    localparam logic [2:0] S_ISSUE    = 3'd2;
    localparam logic [2:0] S_WAIT     = 3'd3;
    localparam logic [2:0] S_CAPTURE  = 3'd4;
    localparam logic [2:0] S_FIN      = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [AW:0] pc_q, pc_d;
    logic [AW:0] len_q, len_d;
    logic [3:0]  cmd_q, cmd_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [6:0]  cap_cnt_q, cap_cnt_d;
    logic [63:0] seen_q, seen_d;
    logic        err_q, err_d;
    logic        seq_done_q, seq_done_d;

    logic [3:0]  script_mem [DEPTH];
    logic [7:0]  fb_mem [64];
    logic        script_we;
    logic        fb_we;
    logic        is_write;
    logic [6:0]  cnt_inc;
    logic [6:0]  cnt_at_done;

    // Code 0 and the undefined codes 12..15 all make the controller run a pixel burst.
    assign is_write    = (cmd_q == 4'd0) || (cmd_q >= 4'd12);
    assign cnt_inc     = (cap_cnt_q == 7'd127) ? 7'd127 : cap_cnt_q + 7'd1;
    assign cnt_at_done = lcd.IRAM_valid ? cnt_inc : cap_cnt_q;

    // Next-state logic for the script player, capture counter and error tracking.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        len_d       = len_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        cap_cnt_d   = cap_cnt_q;
        seen_d      = seen_q;
        err_d       = err_q;
        seq_done_d  = (state_q == S_FIN);
        script_we   = 1'b0;
        fb_we       = 1'b0;

        if ((state_q != S_CAPTURE) && (lcd.IRAM_valid || lcd.done)) begin
            err_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                script_we = cfg_we;
                if (start) begin
                    len_d   = cfg_len;
                    pc_d    = '0;
                    err_d   = 1'b0;
                    state_d = (cfg_len == '0) ? S_FIN : S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (!lcd.busy) begin
                    cmd_d       = script_mem[pc_q[AW-1:0]];
                    cmd_valid_d = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                pc_d    = pc_q + 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Busy is always high here; non-write ops finish this cycle and
                // WAIT_RDY re-checks busy before the next issue.
                if (is_write) begin
                    cap_cnt_d = '0;
                    seen_d    = '0;
                    state_d   = S_CAPTURE;
                end else begin
                    state_d = (pc_q == len_q) ? S_FIN : S_WAIT_RDY;
                end
            end
            S_CAPTURE: begin
                if (lcd.IRAM_valid) begin
                    fb_we     = 1'b1;
                    cap_cnt_d = cnt_inc;
                    seen_d[lcd.IRAM_A] = 1'b1;
                    if (seen_q[lcd.IRAM_A]) begin
                        err_d = 1'b1;
                    end
                end
                if (lcd.done) begin
                    if (cnt_at_done != 7'(NPIX)) begin
                        err_d = 1'b1;
                    end
                    state_d = (pc_q == len_q) ? S_FIN : S_WAIT_RDY;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and control registers; reset aborts straight back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            len_q       <= '0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            cap_cnt_q   <= '0;
            seen_q      <= '0;
            err_q       <= 1'b0;
            seq_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            len_q       <= len_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            cap_cnt_q   <= cap_cnt_d;
            seen_q      <= seen_d;
            err_q       <= err_d;
            seq_done_q  <= seq_done_d;
        end
    end

    // Script memory write port, only opened while idle.
    always_ff @(posedge clk) begin
        if (script_we) begin
            script_mem[cfg_addr] <= cfg_cmd;
        end
    end

    // Frame buffer write port fed by the controller's pixel burst.
    always_ff @(posedge clk) begin
        if (fb_we) begin
            fb_mem[lcd.IRAM_A] <= lcd.IRAM_D;
        end
    end

    assign lcd.cmd       = cmd_q;
    assign lcd.cmd_valid = cmd_valid_q;
    assign fb_data       = fb_mem[fb_addr];
    assign cap_cnt       = cap_cnt_q;
    assign seq_busy      = (state_q != S_IDLE);
    assign seq_done      = seq_done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Testbench for lcd_cmd_sequencer: a behavioural LCD controller answers commands,
// emits pixel bursts and optional stray traffic; expected commands, frame buffer
// contents, counts and error flags come from the script and pixel tables.
module tb_lcd_cmd_sequencer;
    localparam int NPIX = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [5:0] cfg_addr;
    logic [3:0] cfg_cmd;
    logic [6:0] cfg_len;
    logic       start;
    logic [5:0] fb_addr;
    logic [7:0] fb_data;
    logic [6:0] cap_cnt;
    logic       seq_busy;
    logic       seq_done;
    logic       err;

    lcd_cmd_sequencer_if lcd();

    lcd_cmd_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_cmd  (cfg_cmd),
        .cfg_len  (cfg_len),
        .start    (start),
        .lcd      (lcd),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .cap_cnt  (cap_cnt),
        .seq_busy (seq_busy),
        .seq_done (seq_done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // controller model controls and observations
    int         boot_end = 0;
    int         boot_last = -1;
    int         pix_n = 64;
    int         pix_sent = 0;
    bit         stray_en = 1'b0;
    bit         abort = 1'b0;
    logic [5:0] pix_a [64];
    logic [7:0] pix_d [64];
    int         done_cyc [$];

    // sequencer output logs
    int         cv_cyc [$];
    logic [3:0] cv_cmd [$];
    int         sd_cyc [$];

    // reference data
    logic [3:0] script_q [$];
    logic [7:0] fb_ref [64];
    bit         fb_valid [64];
    int         start_cyc;

    // log registered outputs at the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            if (lcd.cmd_valid) begin
                cv_cyc.push_back(cyc);
                cv_cmd.push_back(lcd.cmd);
            end
            if (seq_done) sd_cyc.push_back(cyc);
        end
    end

    // behavioural controller: busy for one cycle on 1-cycle ops, pixel burst on writes
    initial begin : controller
        logic [3:0] c;
        lcd.busy = 1'b0;
        lcd.done = 1'b0;
        lcd.IRAM_valid = 1'b0;
        lcd.IRAM_A = '0;
        lcd.IRAM_D = '0;
        forever begin
            @(negedge clk);
            lcd.IRAM_valid = 1'b0;
            if (lcd.cmd_valid && !reset) begin
                c = lcd.cmd;
                @(negedge clk);
                lcd.busy = 1'b1;
                if (c == 4'd0 || c >= 4'd12) begin
                    pix_sent = 0;
                    for (int p = 0; p < pix_n && !abort; p++) begin
                        @(negedge clk);
                        lcd.IRAM_valid = 1'b1;
                        lcd.IRAM_A = pix_a[p];
                        lcd.IRAM_D = pix_d[p];
                        pix_sent = p + 1;
                    end
                    @(negedge clk);
                    lcd.IRAM_valid = 1'b0;
                    if (!abort) begin
                        lcd.done = 1'b1;
                        done_cyc.push_back(cyc);
                        @(negedge clk);
                        lcd.done = 1'b0;
                    end
                    lcd.busy = 1'b0;
                end else begin
                    @(negedge clk);
                    lcd.busy = 1'b0;
                    if (stray_en) lcd.IRAM_valid = 1'b1;
                end
            end else begin
                lcd.busy = (cyc < boot_end);
                if (lcd.busy) boot_last = cyc;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        cv_cyc.delete();
        cv_cmd.delete();
        sd_cyc.delete();
        done_cyc.delete();
    endtask

    task automatic write_entry(input int a, input logic [3:0] c);
        cfg_we = 1'b1;
        cfg_addr = a[5:0];
        cfg_cmd = c;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // pulse start, optionally poke script/start mid-run, then wait for seq_done
    task automatic applyStimulus(input int len, input int budget, input bit poke, output int s);
        bit seen_done;
        cfg_len = len[6:0];
        start = 1'b1;
        s = cyc;
        @(negedge clk);
        start = 1'b0;
        if (poke) begin
            cfg_we = 1'b1;
            cfg_addr = 6'd0;
            cfg_cmd = 4'd5;
            cfg_len = 7'd1;
            start = 1'b1;
            @(negedge clk);
            cfg_we = 1'b0;
            start = 1'b0;
        end
        seen_done = 1'b0;
        for (int i = 0; i < budget && !seen_done; i++) begin
            @(negedge clk);
            seen_done = (sd_cyc.size() > 0);
        end
        checkOutput("seq_done_within_budget", 32'(seen_done), 1);
        repeat (2) @(negedge clk);
    endtask

    // build a shuffled burst and derive expected frame buffer and error flag
    task automatic make_burst(input int n, input bit dup, output bit e);
        bit seen [64];
        int j;
        logic [5:0] t;
        for (int i = 0; i < 64; i++) begin
            pix_a[i] = 6'(i);
            pix_d[i] = 8'($urandom);
        end
        for (int i = 63; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = pix_a[i];
            pix_a[i] = pix_a[j];
            pix_a[j] = t;
        end
        if (dup) pix_a[9] = pix_a[3];
        pix_n = n;
        e = (n != NPIX);
        for (int i = 0; i < 64; i++) begin
            seen[i] = 1'b0;
            fb_valid[i] = 1'b0;
        end
        for (int p = 0; p < n; p++) begin
            if (seen[pix_a[p]]) e = 1'b1;
            seen[pix_a[p]] = 1'b1;
            fb_ref[pix_a[p]] = pix_d[p];
            fb_valid[pix_a[p]] = 1'b1;
        end
    endtask

    task automatic run_and_check(input string name, input int len, input bit load, input bit poke);
        int s;
        clear_logs();
        if (load) begin
            for (int i = 0; i < script_q.size(); i++) write_entry(i, script_q[i]);
        end
        applyStimulus(len, 2000, poke, s);
        start_cyc = s;
        checkOutput({name, "_ncmd"}, cv_cmd.size(), len);
        for (int i = 0; i < len; i++) begin
            checkOutput($sformatf("%s_cmd%0d", name, i), 32'(cv_cmd[i]), 32'(script_q[i]));
        end
        checkOutput({name, "_nseqdone"}, sd_cyc.size(), 1);
    endtask

    task automatic check_burst(input string name, input int n, input bit e);
        checkOutput({name, "_cap_cnt"}, 32'(cap_cnt), n);
        checkOutput({name, "_err"}, 32'(err), 32'(e));
        for (int a = 0; a < 64; a++) begin
            if (fb_valid[a]) begin
                fb_addr = 6'(a);
                #1;
                checkOutput($sformatf("%s_fb%0d", name, a), 32'(fb_data), 32'(fb_ref[a]));
            end
        end
    endtask

    initial begin : main
        bit e;
        int n;
        int w;
        int r;
        bit dup;
        reset = 1'b1;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_cmd = '0;
        cfg_len = '0;
        start = 1'b0;
        fb_addr = '0;
        repeat (3) @(negedge clk);

        checkOutput("rst_cmd", 32'(lcd.cmd), 0);
        checkOutput("rst_cmd_valid", 32'(lcd.cmd_valid), 0);
        checkOutput("rst_cap_cnt", 32'(cap_cnt), 0);
        checkOutput("rst_seq_done", 32'(seq_done), 0);
        checkOutput("rst_err", 32'(err), 0);
        checkOutput("rst_seq_busy", 32'(seq_busy), 0);

        // controller busy for 66 cycles after reset release
        reset = 1'b0;
        boot_end = cyc + 66;
        @(negedge clk);

        script_q = '{4'd1};
        run_and_check("boot", 1, 1'b1, 1'b0);
        checkOutput("boot_issue_after_busy", cv_cyc[0], boot_last + 2);
        checkOutput("boot_seqdone_delay", sd_cyc[0] - cv_cyc[0], 3);
        checkOutput("boot_err", 32'(err), 0);

        // fixed script ending in a write
        script_q = '{4'd4, 4'd4, 4'd2, 4'd0};
        make_burst(64, 1'b0, e);
        run_and_check("s4420", 4, 1'b1, 1'b0);
        checkOutput("s4420_gap01", cv_cyc[1] - cv_cyc[0], 3);
        checkOutput("s4420_gap12", cv_cyc[2] - cv_cyc[1], 3);
        checkOutput("s4420_done_to_seqdone", sd_cyc[0] - done_cyc[0], 2);
        check_burst("s4420", 64, e);

        // short burst of 63 pixels
        script_q = '{4'd0};
        make_burst(63, 1'b0, e);
        run_and_check("short", 1, 1'b1, 1'b0);
        check_burst("short", 63, e);

        // full-length burst with a repeated address
        script_q = '{4'd13};
        make_burst(64, 1'b1, e);
        run_and_check("dup", 1, 1'b1, 1'b0);
        check_burst("dup", 64, e);

        // stray pixel strobe while waiting to issue
        stray_en = 1'b1;
        script_q = '{4'd7, 4'd1};
        run_and_check("stray", 2, 1'b1, 1'b0);
        checkOutput("stray_err", 32'(err), 1);
        stray_en = 1'b0;
        script_q = '{4'd3};
        run_and_check("clear", 1, 1'b1, 1'b0);
        checkOutput("clear_err", 32'(err), 0);

        // zero-length script
        script_q.delete();
        run_and_check("len0", 0, 1'b0, 1'b0);
        checkOutput("len0_seqdone_cycle", sd_cyc[0], start_cyc + 2);

        // script writes and start pulses during a run are ignored
        script_q = '{4'd1, 4'd3};
        run_and_check("poke", 2, 1'b1, 1'b1);
        run_and_check("rerun", 2, 1'b0, 1'b0);

        // random scripts with one write burst somewhere in the script
        for (int k = 0; k < 3; k++) begin
            n = int'($urandom_range(6, 2));
            w = int'($urandom_range(n - 1, 0));
            script_q.delete();
            for (int i = 0; i < n; i++) begin
                if (i == w) begin
                    r = int'($urandom_range(4, 0));
                    script_q.push_back((r == 0) ? 4'd0 : 4'(11 + r));
                end else begin
                    script_q.push_back(4'($urandom_range(11, 1)));
                end
            end
            dup = ($urandom_range(3, 0) == 0);
            make_burst(64, dup, e);
            run_and_check($sformatf("rnd%0d", k), n, 1'b1, 1'b0);
            check_burst($sformatf("rnd%0d", k), 64, e);
        end

        // full-depth script of non-write commands
        script_q.delete();
        for (int i = 0; i < 64; i++) script_q.push_back(4'($urandom_range(11, 1)));
        run_and_check("len64", 64, 1'b1, 1'b0);
        checkOutput("len64_err", 32'(err), 0);

        // reset in the middle of a capture burst
        clear_logs();
        write_entry(0, 4'd0);
        make_burst(64, 1'b0, e);
        cfg_len = 7'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50 && cv_cyc.size() == 0; i++) @(negedge clk);
        checkOutput("rstcap_issued", cv_cyc.size(), 1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 200 && pix_sent < 20; i++) @(negedge clk);
        checkOutput("rstcap_pix20", 32'(pix_sent >= 20), 1);
        reset = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        checkOutput("rstcap_cmd_valid", 32'(lcd.cmd_valid), 0);
        checkOutput("rstcap_seq_busy", 32'(seq_busy), 0);
        checkOutput("rstcap_cap_cnt", 32'(cap_cnt), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
